// File: rtl/xor_parity_stream.sv
// xor_parity_stream: reduces a valid/ready stream of WIDTH-bit beats to one
// parity bit per frame, with a saturating beat count and per-frame even/odd mode.
// Stage 1 registers the XOR reduction of each accepted beat. A three-state FSM
// folds those word parities into a frame accumulator and presents the result.
module xor_parity_stream #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             s1_valid;
  logic             s1_par;
  logic             s1_last;
  logic             s1_mode;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             accept;
  logic             consume;
  logic             acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // Only a full stage-1 register blocked behind a presented result stalls input.
  assign in_ready = !(s1_valid && state == HOLD);
  assign accept   = in_valid && in_ready;
  assign consume  = s1_valid && state != HOLD;

  // Stage 1: register the word parity; a same-cycle accept refills the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_par   <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_par   <= ^in_data;
      s1_last  <= in_last;
      s1_mode  <= in_mode;
    end else if (consume) begin
      s1_valid <= 1'b0;
    end
  end

  // Frame fold: the first beat seeds acc with the mode, later beats XOR in and count.
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    ovf_next = ovf;
    if (state == IDLE) begin
      acc_next = s1_par ^ s1_mode;
      cnt_next = CNT_ONE;
      ovf_next = 1'b0;
    end else begin
      acc_next = acc ^ s1_par;
      if (cnt == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end
  end

  // Frame FSM with registered result outputs, loaded on the way into HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= 1'b0;
      cnt        <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (consume) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (s1_last) begin
              state      <= HOLD;
              out_valid  <= 1'b1;
              out_parity <= acc_next;
              out_count  <= cnt_next;
              out_ovf    <= ovf_next;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // The buffered beat (if any) waits one more cycle, until IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
